// File: rtl/conn_tuple_store_if.sv
// ----------------------------------------------------------------------------
// conn_tuple_store_if
//   Bundles the learn, query and response signals of conn_tuple_store.
//   master : drives learn writes and queries, observes q_ready and responses
//   slave  : the tuple store itself
//   Signals:
//     wr_tuple/wr_conn/wr_valid : learn a tuple under a connection ID
//     q_conn/q_valid/q_ready    : query handshake
//     r_tuple/r_hit/r_valid     : one-cycle response strobe with result
// ----------------------------------------------------------------------------
interface conn_tuple_store_if #(
    parameter int CONN_W  = 16,
    parameter int TUPLE_W = 128
);
    logic [TUPLE_W-1:0] wr_tuple;
    logic [CONN_W-1:0]  wr_conn;
    logic               wr_valid;
    logic [CONN_W-1:0]  q_conn;
    logic               q_valid;
    logic               q_ready;
    logic [TUPLE_W-1:0] r_tuple;
    logic               r_hit;
    logic               r_valid;

    modport master (
        output wr_tuple, wr_conn, wr_valid, q_conn, q_valid,
        input  q_ready, r_tuple, r_hit, r_valid
    );

    modport slave (
        input  wr_tuple, wr_conn, wr_valid, q_conn, q_valid,
        output q_ready, r_tuple, r_hit, r_valid
    );
endinterface

// File: rtl/conn_tuple_store.sv
// ----------------------------------------------------------------------------
// conn_tuple_store
//   Maps a connection ID back to the flow tuple learned for it. Entries are
//   learned from the tx-side result stream and looked up by ID with a fixed
//   two-cycle pipelined response (query accepted at edge N -> r_valid after
//   edge N+2). After reset the table is swept clean one entry per cycle
//   before queries are accepted.
//   Ports:
//     clk    : sole clock, rising edge
//     reset  : asynchronous, active-high
//     bus    : conn_tuple_store_if.slave (learn, query, response)
//   Optional feature (macro CONN_TUPLE_STORE_STATS_EN):
//     stat_hit, stat_miss, stat_overwrite : saturating 32-bit counters
// ----------------------------------------------------------------------------
module conn_tuple_store #(
    parameter int IDX_W   = 10,
    parameter int CONN_W  = 16,
    parameter int TUPLE_W = 128
) (
    input  logic clk,
    input  logic reset,
    conn_tuple_store_if.slave bus
`ifdef CONN_TUPLE_STORE_STATS_EN
    ,
    output logic [31:0] stat_hit,
    output logic [31:0] stat_miss,
    output logic [31:0] stat_overwrite
`endif
);
    localparam int DEPTH = 1 << IDX_W;

    typedef enum logic {ST_INIT, ST_RUN} state_t;

    typedef struct packed {
        logic               valid;
        logic [CONN_W-1:0]  tag;
        logic [TUPLE_W-1:0] tuple;
    } entry_t;

    state_t             r_state;
    state_t             w_state_nxt;
    logic [IDX_W-1:0]   r_clr_idx;
    entry_t             r_mem [DEPTH];

    logic               w_run;
    logic               w_q_accept;
    logic               w_wr_en;
    logic [IDX_W-1:0]   w_wr_idx;
    entry_t             w_wr_entry;
    logic               w_mem_we;
    logic [IDX_W-1:0]   w_mem_idx;
    entry_t             w_mem_data;

    logic               r_s1_valid;
    logic [CONN_W-1:0]  r_s1_conn;
    logic [IDX_W-1:0]   w_s1_idx;
    entry_t             w_rd_entry;
    logic               r_s2_valid;
    logic [CONN_W-1:0]  r_s2_conn;
    entry_t             r_s2_entry;
    logic               w_hit;

    logic               r_rsp_valid;
    logic               r_rsp_hit;
    logic [TUPLE_W-1:0] r_rsp_tuple;

    assign w_run      = (r_state == ST_RUN);
    assign w_q_accept = bus.q_valid && w_run;
    assign w_wr_en    = bus.wr_valid && w_run;
    assign w_wr_idx   = bus.wr_conn[IDX_W-1:0];
    assign w_wr_entry = {1'b1, bus.wr_conn, bus.wr_tuple};

    // ---------------- FSM: INIT sweep, then terminal RUN ----------------
    always_ff @(posedge clk or posedge reset) begin
        // NOTE: sequential state uses non-blocking assignments so every
        // register samples pre-edge values regardless of block ordering.
        if (reset) begin
            r_state   <= ST_INIT;
            r_clr_idx <= '0;
        end else begin
            r_state <= w_state_nxt;
            if (r_state == ST_INIT)
                r_clr_idx <= r_clr_idx + IDX_W'(1);
        end
    end

    always_comb begin
        // NOTE: defaults first so no path leaves a signal unassigned (no latch).
        w_state_nxt = r_state;
        if (r_state == ST_INIT && r_clr_idx == '1)
            w_state_nxt = ST_RUN;
    end

    // ---------------- Table write port: clear sweep or learn ----------------
    always_comb begin
        w_mem_we   = 1'b0;
        w_mem_idx  = w_wr_idx;
        w_mem_data = w_wr_entry;
        if (r_state == ST_INIT) begin
            w_mem_we   = 1'b1;
            w_mem_idx  = r_clr_idx;
            w_mem_data = '0;
        end else if (w_wr_en) begin
            w_mem_we = 1'b1;
        end
    end

    // NOTE: the table has no reset; the INIT sweep clears valid bits instead,
    // which keeps it mappable onto block RAM.
    always_ff @(posedge clk) begin
        if (w_mem_we)
            r_mem[w_mem_idx] <= w_mem_data;
    end

    // ---------------- Query pipeline ----------------
    // The read is taken from the stage-1 address. A write landing on the
    // same edge is forwarded so the response is read-after-write coherent;
    // a write on the accept edge is already in the table by then.
    assign w_s1_idx   = r_s1_conn[IDX_W-1:0];
    assign w_rd_entry = (w_wr_en && (w_wr_idx == w_s1_idx)) ? w_wr_entry
                                                            : r_mem[w_s1_idx];
    assign w_hit      = r_s2_entry.valid && (r_s2_entry.tag == r_s2_conn);

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            r_s1_valid  <= 1'b0;
            r_s1_conn   <= '0;
            r_s2_valid  <= 1'b0;
            r_s2_conn   <= '0;
            r_s2_entry  <= '0;
            r_rsp_valid <= 1'b0;
            r_rsp_hit   <= 1'b0;
            r_rsp_tuple <= '0;
        end else begin
            r_s1_valid <= w_q_accept;
            if (w_q_accept)
                r_s1_conn <= bus.q_conn;
            r_s2_valid <= r_s1_valid;
            if (r_s1_valid) begin
                r_s2_conn  <= r_s1_conn;
                r_s2_entry <= w_rd_entry;
            end
            // Result fields hold their last value between responses.
            r_rsp_valid <= r_s2_valid;
            if (r_s2_valid) begin
                r_rsp_hit   <= w_hit;
                r_rsp_tuple <= w_hit ? r_s2_entry.tuple : '0;
            end
        end
    end

    assign bus.q_ready = w_run;
    assign bus.r_valid = r_rsp_valid;
    assign bus.r_hit   = r_rsp_hit;
    assign bus.r_tuple = r_rsp_tuple;

`ifdef CONN_TUPLE_STORE_STATS_EN
    // ---------------- Saturating statistics ----------------
    entry_t w_old_entry;
    logic   w_overwrite;
    logic [31:0] r_stat_hit;
    logic [31:0] r_stat_miss;
    logic [31:0] r_stat_overwrite;

    // Overwrite = a learn that evicts a live entry belonging to another ID.
    assign w_old_entry = r_mem[w_wr_idx];
    assign w_overwrite = w_wr_en && w_old_entry.valid
                         && (w_old_entry.tag != bus.wr_conn);

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            r_stat_hit       <= '0;
            r_stat_miss      <= '0;
            r_stat_overwrite <= '0;
        end else if (w_run) begin
            if (r_s2_valid && w_hit && r_stat_hit != '1)
                r_stat_hit <= r_stat_hit + 32'd1;
            if (r_s2_valid && !w_hit && r_stat_miss != '1)
                r_stat_miss <= r_stat_miss + 32'd1;
            if (w_overwrite && r_stat_overwrite != '1)
                r_stat_overwrite <= r_stat_overwrite + 32'd1;
        end
    end

    assign stat_hit       = r_stat_hit;
    assign stat_miss      = r_stat_miss;
    assign stat_overwrite = r_stat_overwrite;
`endif
endmodule

// File: tb/tb_conn_tuple_store.sv
// ----------------------------------------------------------------------------
// tb_conn_tuple_store
//   Self-checking bench for conn_tuple_store (default parameters). A reference
//   model keeps the table as plain arrays indexed by conn[9:0] and applies the
//   visibility rule directly: a query accepted at edge N sees every write
//   accepted up to edge N+1 and responds after edge N+2. A negedge monitor
//   compares every cycle; scenario tasks add directed comparisons.
//   Build with +define+CONN_TUPLE_STORE_STATS_EN to also compare counters.
// ----------------------------------------------------------------------------
module tb_conn_tuple_store;
    localparam int DEPTH = 1024;

    logic clk = 1'b0;
    logic reset = 1'b1;
    always #5 clk = ~clk;

    conn_tuple_store_if #(.CONN_W(16), .TUPLE_W(128)) bus ();

`ifdef CONN_TUPLE_STORE_STATS_EN
    logic [31:0] stat_hit, stat_miss, stat_overwrite;
`endif

    conn_tuple_store #(.IDX_W(10), .CONN_W(16), .TUPLE_W(128)) dut (
        .clk   (clk),
        .reset (reset),
        .bus   (bus)
`ifdef CONN_TUPLE_STORE_STATS_EN
        ,
        .stat_hit       (stat_hit),
        .stat_miss      (stat_miss),
        .stat_overwrite (stat_overwrite)
`endif
    );

    int checks   = 0;
    int failures = 0;

    // ---------------- Reference model ----------------
    typedef struct { logic [15:0] conn; int acc_edge; } acc_t;
    typedef struct { logic hit; logic [127:0] tuple; int due; } rsp_t;

    bit           m_valid [DEPTH];
    logic [15:0]  m_conn  [DEPTH];
    logic [127:0] m_tuple [DEPTH];
    acc_t         acc_q[$];
    rsp_t         rsp_q[$];
    int           edge_no = 0;
    logic         exp_rv = 1'b0;
    logic         exp_hit = 1'b0;
    logic [127:0] exp_tuple = '0;
    int unsigned  m_hits = 0, m_misses = 0, m_overwrites = 0;
    int           m_idx;
    bit           m_run;
    rsp_t         m_rsp;

    always @(posedge clk or posedge reset) begin
        if (reset) begin
            acc_q.delete();
            rsp_q.delete();
            edge_no = 0;
            exp_rv  = 1'b0;
            m_hits = 0; m_misses = 0; m_overwrites = 0;
            for (int i = 0; i < DEPTH; i++) m_valid[i] = 1'b0;
        end else begin
            edge_no++;
            m_run = (edge_no > DEPTH);
            if (m_run && bus.wr_valid) begin
                m_idx = int'(bus.wr_conn) % DEPTH;
                if (m_valid[m_idx] && m_conn[m_idx] != bus.wr_conn) m_overwrites++;
                m_valid[m_idx] = 1'b1;
                m_conn[m_idx]  = bus.wr_conn;
                m_tuple[m_idx] = bus.wr_tuple;
            end
            // Queries accepted one edge ago have now seen every write they can.
            while (acc_q.size() > 0 && acc_q[0].acc_edge == edge_no - 1) begin
                m_idx       = int'(acc_q[0].conn) % DEPTH;
                m_rsp.hit   = m_valid[m_idx] && (m_conn[m_idx] == acc_q[0].conn);
                m_rsp.tuple = m_rsp.hit ? m_tuple[m_idx] : 128'd0;
                m_rsp.due   = edge_no + 1;
                rsp_q.push_back(m_rsp);
                void'(acc_q.pop_front());
            end
            if (m_run && bus.q_valid)
                acc_q.push_back('{conn: bus.q_conn, acc_edge: edge_no});
            exp_rv = 1'b0;
            if (rsp_q.size() > 0 && rsp_q[0].due == edge_no) begin
                exp_rv    = 1'b1;
                exp_hit   = rsp_q[0].hit;
                exp_tuple = rsp_q[0].tuple;
                if (exp_hit) m_hits++; else m_misses++;
                void'(rsp_q.pop_front());
            end
        end
    end

    // ---------------- Cycle monitor ----------------
    logic exp_qr;
    always @(negedge clk) begin
        exp_qr = (!reset && edge_no >= DEPTH);
        checks++;
        if (bus.q_ready !== exp_qr) begin
            failures++;
            $display("FAIL mon_q_ready edge=%0d got=%b exp=%b", edge_no, bus.q_ready, exp_qr);
        end
        checks++;
        if (bus.r_valid !== exp_rv) begin
            failures++;
            $display("FAIL mon_r_valid edge=%0d got=%b exp=%b", edge_no, bus.r_valid, exp_rv);
        end
        if (exp_rv) begin
            checks++;
            if (bus.r_hit !== exp_hit) begin
                failures++;
                $display("FAIL mon_r_hit edge=%0d got=%b exp=%b", edge_no, bus.r_hit, exp_hit);
            end
            checks++;
            if (bus.r_tuple !== exp_tuple) begin
                failures++;
                $display("FAIL mon_r_tuple edge=%0d got=%h exp=%h", edge_no, bus.r_tuple, exp_tuple);
            end
        end
    end

    // ---------------- Stimulus helpers ----------------
    // Called 2ns after a rising edge; drives one edge worth of inputs.
    task automatic cyc(input logic wv, input logic [15:0] wc, input logic [127:0] wt,
                       input logic qv, input logic [15:0] qc);
        bus.wr_valid = wv; bus.wr_conn = wc; bus.wr_tuple = wt;
        bus.q_valid  = qv; bus.q_conn  = qc;
        @(posedge clk); #2;
        bus.wr_valid = 1'b0;
        bus.q_valid  = 1'b0;
    endtask

    task automatic idle(input int n);
        for (int i = 0; i < n; i++) cyc(1'b0, 16'h0, 128'h0, 1'b0, 16'h0);
    endtask

    function automatic logic [127:0] rand_tuple();
        return {$urandom, $urandom, $urandom, $urandom};
    endfunction

    // ---------------- Scenarios ----------------
    task automatic test_reset();
        bus.wr_valid = 1'b0; bus.wr_conn = '0; bus.wr_tuple = '0;
        bus.q_valid  = 1'b0; bus.q_conn  = '0;
        repeat (3) @(posedge clk);
        #2;
        if (bus.q_ready !== 1'b0) begin failures++; $display("FAIL rst_q_ready got=%b exp=0", bus.q_ready); end
        checks++;
        if (bus.r_valid !== 1'b0) begin failures++; $display("FAIL rst_r_valid got=%b exp=0", bus.r_valid); end
        checks++;
        if (bus.r_hit !== 1'b0) begin failures++; $display("FAIL rst_r_hit got=%b exp=0", bus.r_hit); end
        checks++;
        if (bus.r_tuple !== 128'd0) begin failures++; $display("FAIL rst_r_tuple got=%h exp=0", bus.r_tuple); end
        checks++;
`ifdef CONN_TUPLE_STORE_STATS_EN
        if (stat_hit !== 32'd0 || stat_miss !== 32'd0 || stat_overwrite !== 32'd0) begin
            failures++;
            $display("FAIL rst_stats got=%0d/%0d/%0d exp=0/0/0", stat_hit, stat_miss, stat_overwrite);
        end
        checks++;
`endif
    endtask

    // Releases reset and idles through INIT; a write at INIT cycle 10 must be dropped.
    task automatic test_init(input bit write_during_init);
        reset = 1'b0;
        for (int i = 0; i < DEPTH; i++) begin
            if (write_during_init && i == 10) cyc(1'b1, 16'h0001, rand_tuple(), 1'b0, 16'h0);
            else idle(1);
            if (i == DEPTH - 2) begin
                checks++;
                if (bus.q_ready !== 1'b0) begin failures++; $display("FAIL init_q_ready_1023 got=%b exp=0", bus.q_ready); end
            end
        end
        checks++;
        if (bus.q_ready !== 1'b1) begin failures++; $display("FAIL init_q_ready_1024 got=%b exp=1", bus.q_ready); end
    endtask

    task automatic expect_rsp(input string name, input logic hit, input logic [127:0] tuple);
        checks++;
        if (bus.r_valid !== 1'b1 || bus.r_hit !== hit || bus.r_tuple !== tuple) begin
            failures++;
            $display("FAIL %s got v=%b h=%b t=%h exp v=1 h=%b t=%h",
                     name, bus.r_valid, bus.r_hit, bus.r_tuple, hit, tuple);
        end
    endtask

    task automatic test_miss_and_dropped_write();
        cyc(1'b0, 16'h0, 128'h0, 1'b1, 16'h0005);
        idle(2);
        expect_rsp("miss_0005", 1'b0, 128'd0);
        cyc(1'b0, 16'h0, 128'h0, 1'b1, 16'h0001);
        idle(2);
        expect_rsp("init_write_dropped", 1'b0, 128'd0);
    endtask

    task automatic test_learn();
        logic [127:0] ta;
        ta = {32'hAAAAAAAA, 32'hAAAAAAAA, 32'hAAAAAAAA, 32'hAAAAAA01};
        cyc(1'b1, 16'h0123, ta, 1'b0, 16'h0);
        cyc(1'b0, 16'h0, 128'h0, 1'b1, 16'h0123);
        idle(2);
        expect_rsp("learn_hit_0123", 1'b1, ta);
        cyc(1'b0, 16'h0, 128'h0, 1'b1, 16'h0523);
        idle(2);
        expect_rsp("tag_miss_0523", 1'b0, 128'd0);
    endtask

    task automatic test_back_to_back();
        logic [127:0] ta;
        ta = {32'hAAAAAAAA, 32'hAAAAAAAA, 32'hAAAAAAAA, 32'hAAAAAA01};
        cyc(1'b0, 16'h0, 128'h0, 1'b1, 16'h0123);
        cyc(1'b0, 16'h0, 128'h0, 1'b1, 16'h0200);
        cyc(1'b0, 16'h0, 128'h0, 1'b1, 16'h0123);
        expect_rsp("b2b_0", 1'b1, ta);
        idle(1);
        expect_rsp("b2b_1", 1'b0, 128'd0);
        idle(1);
        expect_rsp("b2b_2", 1'b1, ta);
        idle(1);
        checks++;
        if (bus.r_valid !== 1'b0) begin failures++; $display("FAIL b2b_end got=%b exp=0", bus.r_valid); end
    endtask

    task automatic test_collision();
        logic [127:0] t1, t2, t3;
        t1 = rand_tuple(); t2 = rand_tuple(); t3 = rand_tuple();
        cyc(1'b1, 16'h0010, t1, 1'b1, 16'h0010);
        idle(2);
        expect_rsp("same_cycle_fwd", 1'b1, t1);
        cyc(1'b1, 16'h0410, t2, 1'b0, 16'h0);
        cyc(1'b0, 16'h0, 128'h0, 1'b1, 16'h0010);
        idle(2);
        expect_rsp("evicted_0010", 1'b0, 128'd0);
`ifdef CONN_TUPLE_STORE_STATS_EN
        checks++;
        if (stat_overwrite !== 32'd1) begin failures++; $display("FAIL stat_overwrite got=%0d exp=1", stat_overwrite); end
`endif
        // Write lands while the query sits in stage 1.
        cyc(1'b0, 16'h0, 128'h0, 1'b1, 16'h0777);
        cyc(1'b1, 16'h0777, t3, 1'b0, 16'h0);
        idle(1);
        expect_rsp("stage1_fwd", 1'b1, t3);
    endtask

    task automatic test_random(input int n);
        logic [15:0] wc, qc;
        for (int i = 0; i < n; i++) begin
            wc = {6'($urandom_range(0, 3)), 10'(10'h030 + $urandom_range(0, 7))};
            qc = {6'($urandom_range(0, 3)), 10'(10'h030 + $urandom_range(0, 7))};
            cyc(1'($urandom_range(0, 1)), wc, rand_tuple(), 1'($urandom_range(0, 1)), qc);
        end
        idle(3);
`ifdef CONN_TUPLE_STORE_STATS_EN
        checks++;
        if (stat_hit !== m_hits || stat_miss !== m_misses || stat_overwrite !== m_overwrites) begin
            failures++;
            $display("FAIL stats_random got=%0d/%0d/%0d exp=%0d/%0d/%0d",
                     stat_hit, stat_miss, stat_overwrite, m_hits, m_misses, m_overwrites);
        end
`endif
    endtask

    task automatic test_reset_midflight();
        cyc(1'b0, 16'h0, 128'h0, 1'b1, 16'h0123);
        cyc(1'b0, 16'h0, 128'h0, 1'b1, 16'h0777);
        reset = 1'b1;
        #1;
        checks++;
        if (bus.r_valid !== 1'b0 || bus.q_ready !== 1'b0) begin
            failures++;
            $display("FAIL midflight_reset got v=%b rdy=%b exp v=0 rdy=0", bus.r_valid, bus.q_ready);
        end
        @(posedge clk); #2;
        @(posedge clk); #2;
        test_init(1'b0);
        cyc(1'b0, 16'h0, 128'h0, 1'b1, 16'h0123);
        idle(2);
        expect_rsp("post_reset_miss", 1'b0, 128'd0);
    endtask

    initial begin
        #2_000_000;
        $display("FAIL watchdog time limit reached");
        $fatal(1, "watchdog");
    end

    initial begin
        test_reset();
        test_init(1'b1);
        test_miss_and_dropped_write();
        test_learn();
        test_back_to_back();
        test_collision();
        test_random(400);
        test_reset_midflight();
        idle(2);
        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end
endmodule

// File: doc/conn_tuple_store.md
# conn_tuple_store

Reverse-direction responder of the NAT connection lookup. The `hash` block maps a 128-bit flow tuple to a 16-bit connection ID. This block maps a connection ID back to its stored tuple, so the rx `main` datapath can restore original addresses. It learns entries from the tx-side result stream (tuple plus assigned connection ID) and answers ID queries with a fixed two-cycle pipelined response.

## Interface
- `IDX_W`, default 10: table index width; depth = 2^IDX_W entries.
- `CONN_W`, default 16: connection ID width.
- `TUPLE_W`, default 128: tuple width; the tuple is treated as opaque.
- `clk`  in  1  sole clock; all logic is on the rising edge.
- `reset`  in  1  asynchronous, active-high reset.
- `wr_tuple`  in  TUPLE_W  tuple to learn.
- `wr_conn`  in  CONN_W  connection ID assigned to `wr_tuple`.
- `wr_valid`  in  1  learn strobe, single-cycle qualifier; no backpressure.
- `q_conn`  in  CONN_W  connection ID to resolve.
- `q_valid`  in  1  query request.
- `q_ready`  out  1  query accepted when `q_valid && q_ready`.
- `r_tuple`  out  TUPLE_W  resolved tuple; all zeros on a miss.
- `r_hit`  out  1  entry was present and its tag matched.
- `r_valid`  out  1  one-cycle response strobe; no backpressure.

## Operation
- Entry layout: {valid, tag[CONN_W-1:0], tuple}. Index = `conn[IDX_W-1:0]`. The tag is the full `conn`.
- FSM states:
  - INIT: sweeps `clr_idx` from 0 to 2^IDX_W-1, writing valid=0 at each index, one entry per cycle. `q_ready`=0. Writes are dropped.
  - RUN: `q_ready`=1. Entered on the cycle after `clr_idx` reaches its maximum. RUN is terminal until reset.
- Learn (RUN only): `wr_valid` writes {1, `wr_conn`, `wr_tuple`} at index `wr_conn[IDX_W-1:0]`. A write overwrites any existing entry, including one with a different tag.
- Query pipeline:
  - Stage 1 registers `q_conn` and the accept flag, and issues the table read.
  - Stage 2 compares the tag and the valid bit, then drives the response registers.
  - Throughput is one query per cycle.
- Hit rule: `r_hit`=1 iff valid=1 and tag == queried `conn`. On a miss, `r_tuple` is forced to 0.
- Write/read collision: a write in the same cycle a query is accepted to the same index is forwarded. The response reflects the new entry. A write landing while a query is in stage 1 is also forwarded, so the result is read-after-write coherent.
- Reset mid-operation: in-flight queries are discarded, no `r_valid` is produced, and the FSM re-enters INIT at `clr_idx`=0.

## Timing
- Reset values:
  - `q_ready`=0, `r_valid`=0, `r_hit`=0, `r_tuple`=0.
  - FSM=INIT, `clr_idx`=0.
  - Pipeline valid flags = 0.
- INIT occupies 2^IDX_W cycles after reset deassertion. `q_ready` rises on the following cycle (cycle 1024 at default).
- Query accepted at edge N → `r_valid`=1 for exactly one cycle after edge N+2.
- `r_tuple` and `r_hit` are held between responses. They are only meaningful while `r_valid`=1.
- A write accepted at edge N is visible to any query accepted at edge ≥ N-1.
- No combinational path from any input to any output. `q_ready` depends on FSM state only.

## Configuration
- `CONN_TUPLE_STORE_STATS_EN`
  - Defined: adds outputs `stat_hit` and `stat_miss` (32 bits each), plus `stat_overwrite` (32 bits). `stat_overwrite` counts writes that replaced a valid entry whose tag differed.
  - The counters saturate at 0xFFFFFFFF, reset to 0, and do not count during INIT.
  - Undefined: these ports and the counter logic are absent. All other behaviour is identical.

## Test plan
- Reset, then idle: `q_ready`=0 for 1024 cycles and 1 on cycle 1024. No `r_valid` appears. Query ID 0x0005 → `r_valid` 2 cycles later with `r_hit`=0 and `r_tuple`=0.
- Write {conn 0x0123, tuple 0xAAAA…01}, then query 0x0123 → `r_hit`=1 and `r_tuple`=0xAAAA…01 at N+2. Query 0x0523 (same index, different tag) → `r_hit`=0.
- Back-to-back queries 0x0123, 0x0200, 0x0123 on consecutive cycles → three consecutive `r_valid` pulses with hit, miss, hit.
- Same-cycle write of conn 0x0010 (tuple T1) with a query of 0x0010 → `r_hit`=1 and `r_tuple`=T1. Then write 0x0410 (tuple T2) and query 0x0010 → miss. With STATS_EN, `stat_overwrite`=1.
- Assert `reset` with two queries in flight → no `r_valid`, `q_ready`=0 immediately. The entry written before reset reads as a miss after INIT.
- Writes issued during INIT are dropped: write 0x0001 at cycle 10 of INIT, then query after INIT → `r_hit`=0.
